sprite_plotter: RTL
===================

// Module: sprite_plotter
// PURPOSE
//   Turns a "move sprite" request into one pixel write per cycle for vga_adapter (160x120, 3-bit colour).
//   Erases the W x H box at the old position with BG_COLOUR, then draws the box at the new position.
//   Sits between the movement datapath (supplies positions) and vga_adapter (consumes x/y/colour/plot).
//   Pixels outside the screen are suppressed. Fixed, position-independent latency.
// PARAMETERS
//   W          4       sprite width in pixels (1..16)
//   H          4       sprite height in pixels (1..16)
//   SCREEN_W   160     visible columns; x >= SCREEN_W is clipped
//   SCREEN_H   120     visible rows; y >= SCREEN_H is clipped
//   BG_COLOUR  3'b000  colour written during erase
// PORTS
//   clk         in   1  system clock (CLOCK_50 domain)
//   reset_n     in   1  synchronous, active-low reset
//   start       in   1  request strobe; sampled only in IDLE
//   erase_en    in   1  1 = erase old box before draw; 0 = draw only
//   old_x       in   8  top-left x of box to erase
//   old_y       in   7  top-left y of box to erase
//   new_x       in   8  top-left x of box to draw
//   new_y       in   7  top-left y of box to draw
//   colour      in   3  sprite colour for draw pass
//   x_out       out  8  pixel x to vga_adapter
//   y_out       out  7  pixel y to vga_adapter
//   colour_out  out  3  pixel colour to vga_adapter
//   plot        out  1  write enable to vga_adapter
//   busy        out  1  high from the cycle after start acceptance until done
//   done        out  1  one-cycle pulse when the request completes
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low. All outputs are registered.
//   - Reset values: x_out=0, y_out=0, colour_out=0, plot=0, busy=0, done=0. FSM returns to IDLE.
//   - Reset mid-operation aborts the request at once. No further plot is issued.
//   - FSM states: IDLE -> ERASE -> DRAW -> FINISH -> IDLE.
//       IDLE:   start=1 latches all request inputs. Goes to ERASE if erase_en=1, else to DRAW.
//       ERASE:  scans box at (old_x,old_y) with BG_COLOUR.
//       DRAW:   scans box at (new_x,new_y) with the latched colour.
//       FINISH: done=1 and busy=0 for exactly one cycle, then IDLE.
//   - Scan order is row-major: dx counts 0..W-1 fastest, dy counts 0..H-1. One pixel per cycle.
//     Each pass therefore takes exactly W*H cycles.
//   - Pixel address: px = base_x + dx, computed at 9 bits; py = base_y + dy, computed at 8 bits.
//     plot=1 only if px < SCREEN_W and py < SCREEN_H. Otherwise plot=0, but the scan still advances.
//     x_out and y_out carry the truncated px[7:0] and py[6:0] regardless of plot.
//   - Latency: start accepted at cycle T; first pixel valid at T+1.
//     erase_en=1: done at T+2*W*H+1. erase_en=0: done at T+W*H+1.
//   - start while busy is ignored; it is not queued. Inputs changing while busy have no effect.
//   - start sampled in the FINISH cycle is ignored. The earliest re-accept is the cycle after done.
//   - An old box equal to or overlapping the new box is still fully erased, then fully drawn.
//   - plot=0 in IDLE and FINISH. colour_out holds its last value when plot=0.
// TESTING (W=H=4)
//   1. start at T, erase_en=1, old=(10,20), new=(11,20), colour=110
//      -> 16 plots of 000 covering x10-13/y20-23 in row-major order,
//      -> then 16 plots of 110 covering x11-14/y20-23,
//      -> done at T+33, busy high T+1..T+32.
//   2. erase_en=0, new=(158,118) -> 4 plots only: (158,118),(159,118),(158,119),(159,119);
//      -> done still at T+17.
//   3. new=(255,127), erase_en=0 -> no plot asserted at all; done at T+17 (wrap is not drawn).
//   4. Second start pulsed at T+5 while busy -> ignored; exactly one done; pixel stream identical to test 1.
//   5. reset_n=0 at T+10 of test 1 -> next cycle plot=0, busy=0, done=0, x_out=0, y_out=0.
//      -> A fresh start then behaves exactly as in test 1.
//   6. start held high continuously -> back-to-back requests;
//      -> each new request is accepted in the cycle after its predecessor's done, with no overlap.

Source files
------------

// File: rtl/sprite_plotter.sv
// sprite_plotter: erases a W x H box at the old position, then draws it at the new one.
// It issues one pixel per cycle to vga_adapter and suppresses pixels that fall off screen.
module sprite_plotter #(
  parameter int unsigned W         = 4,
  parameter int unsigned H         = 4,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       erase_en,
  input  logic [7:0] old_x,
  input  logic [6:0] old_y,
  input  logic [7:0] new_x,
  input  logic [6:0] new_y,
  input  logic [2:0] colour,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

  state_t        state;
  logic [CW-1:0] dx, dy;
  logic [7:0]    old_x_q, new_x_q;
  logic [6:0]    old_y_q, new_y_q;
  logic [2:0]    colour_q;

  logic          row_end, last, emit;
  logic [CW-1:0] nxt_dx, nxt_dy;
  logic [7:0]    base_x;
  logic [6:0]    base_y;
  logic [2:0]    pix_colour;
  logic [8:0]    px;
  logic [7:0]    py;
  logic          visible;

  // Next pixel to present: offsets, base corner, colour and on-screen test
  always_comb begin
    row_end    = (dx == CW'(W - 1));
    last       = row_end && (dy == CW'(H - 1));
    nxt_dx     = row_end ? '0 : dx + CW'(1);
    nxt_dy     = row_end ? dy + CW'(1) : dy;
    base_x     = new_x_q;
    base_y     = new_y_q;
    pix_colour = colour_q;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        emit       = start;
        nxt_dx     = '0;
        nxt_dy     = '0;
        base_x     = erase_en ? old_x : new_x;
        base_y     = erase_en ? old_y : new_y;
        pix_colour = erase_en ? BG_COLOUR : colour;
      end
      ERASE: begin
        emit = 1'b1;
        if (last) begin
          // Erase pass ends; the first draw pixel follows immediately
          nxt_dx = '0;
          nxt_dy = '0;
        end else begin
          base_x     = old_x_q;
          base_y     = old_y_q;
          pix_colour = BG_COLOUR;
        end
      end
      DRAW:    emit = !last;
      default: emit = 1'b0;
    endcase
    px      = 9'(base_x) + 9'(nxt_dx);
    py      = 8'(base_y) + 8'(nxt_dy);
    visible = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
  end

  // Sequencer and registered pixel outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      dx         <= '0;
      dy         <= '0;
      old_x_q    <= '0;
      old_y_q    <= '0;
      new_x_q    <= '0;
      new_y_q    <= '0;
      colour_q   <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (start) begin
            old_x_q  <= old_x;
            old_y_q  <= old_y;
            new_x_q  <= new_x;
            new_y_q  <= new_y;
            colour_q <= colour;
            busy     <= 1'b1;
            state    <= erase_en ? ERASE : DRAW;
          end
        end
        ERASE: begin
          if (last) state <= DRAW;
        end
        DRAW: begin
          if (last) begin
            state <= FINISH;
            plot  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (emit) begin
        dx    <= nxt_dx;
        dy    <= nxt_dy;
        x_out <= px[7:0];
        y_out <= py[6:0];
        plot  <= visible;
        if (visible) colour_out <= pix_colour;
      end
    end
  end

endmodule
